// File: rtl/jt49_eg_timer.sv
// jt49_eg_timer: envelope period timer for the JT49 envelope generator.
// Counts cen pulses against a PW-bit period register and emits one-clk
// eg_cen steps; a shape write latches ctrl, clears the count and pulses
// restart. Optional macro JT49_EG_ZERO_HALT_EN makes period=0 halt the
// timer instead of behaving as period=1.
module jt49_eg_timer #(
  parameter int PW = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       we_fine,
  input  logic       we_coarse,
  input  logic       we_shape,
  output logic       eg_cen,
  output logic       restart,
  output logic [3:0] ctrl
);

  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic          eg_cen_q, eg_cen_d;
  logic          restart_q, restart_d;

  logic [PW-9:0] coarse_w;
  logic [PW-1:0] eff_period;
  logic [PW:0]   cnt_inc;
  logic          halt;
  logic          terminal;

  // Upper period bits come from the low bits of din (zero-extended if PW > 16).
  assign coarse_w = (PW-8)'(din);

  // Period register: both halves may be written on the same edge, cen-independent.
  always_comb begin
    period_d = period_q;
    if (we_fine)   period_d[7:0]    = din;
    if (we_coarse) period_d[PW-1:8] = coarse_w;
  end

  // Terminal detect against the period in force before this edge's writes;
  // compare is one bit wider so a shrunken period never wraps the counter.
  always_comb begin
    eff_period = (period_q == '0) ? PW'(1) : period_q;
    cnt_inc    = {1'b0, cnt_q} + (PW+1)'(1);
`ifdef JT49_EG_ZERO_HALT_EN
    halt       = (period_q == '0);
`else
    halt       = 1'b0;
`endif
    terminal   = cen & ~halt & (cnt_inc >= {1'b0, eff_period});
  end

  // Counter, shape latch and pulse generation; a shape write beats a terminal cen.
  always_comb begin
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    eg_cen_d  = 1'b0;
    restart_d = 1'b0;
    if (we_shape) begin
      ctrl_d    = din[3:0];
      cnt_d     = '0;
      restart_d = 1'b1;
    end else if (halt) begin
      cnt_d = '0;
    end else if (terminal) begin
      cnt_d    = '0;
      eg_cen_d = 1'b1;
    end else if (cen) begin
      cnt_d = cnt_inc[PW-1:0];
    end
  end

  // State registers; reset drops any in-flight pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q  <= '0;
      cnt_q     <= '0;
      ctrl_q    <= 4'd0;
      eg_cen_q  <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      eg_cen_q  <= eg_cen_d;
      restart_q <= restart_d;
    end
  end

  assign eg_cen  = eg_cen_q;
  assign restart = restart_q;
  assign ctrl    = ctrl_q;

endmodule

// File: tb/tb_jt49_eg_timer.sv
// tb_jt49_eg_timer: directed scenarios plus $urandom traffic, checked every
// cycle against a cen-counting reference model.
module tb_jt49_eg_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic [7:0] din = 8'h00;
  logic       we_fine = 1'b0, we_coarse = 1'b0, we_shape = 1'b0;
  logic       eg_cen, restart;
  logic [3:0] ctrl;

  jt49_eg_timer #(.PW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .din(din),
    .we_fine(we_fine), .we_coarse(we_coarse), .we_shape(we_shape),
    .eg_cen(eg_cen), .restart(restart), .ctrl(ctrl)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: period as an integer, number of cen pulses seen since
  // the last step/clear, and the outputs expected after the next clock.
  int         m_period = 0;
  int         m_seen   = 0;
  logic [3:0] m_ctrl   = 4'd0;
  logic       x_eg     = 1'b0;
  logic       x_rs     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: check the outputs of the previous edge, then drive inputs
  // for the next edge and advance the model by one clock.
  task automatic step(input bit r, input bit c, input bit f, input bit co,
                      input bit s, input logic [7:0] d);
    int  eff;
    bit  halt;
    @(negedge clk);
    chk("eg_cen",  {31'd0, eg_cen},  {31'd0, x_eg});
    chk("restart", {31'd0, restart}, {31'd0, x_rs});
    chk("ctrl",    {28'd0, ctrl},    {28'd0, m_ctrl});
    chk("excl",    {31'd0, eg_cen & restart}, 32'd0);
    rst_n = r; cen = c; we_fine = f; we_coarse = co; we_shape = s; din = d;
    x_eg = 1'b0; x_rs = 1'b0;
    if (!r) begin
      m_period = 0; m_seen = 0; m_ctrl = 4'd0;
    end else begin
      eff = (m_period == 0) ? 1 : m_period;
`ifdef JT49_EG_ZERO_HALT_EN
      halt = (m_period == 0);
`else
      halt = 1'b0;
`endif
      if (s) begin
        m_ctrl = d[3:0]; m_seen = 0; x_rs = 1'b1;
      end else if (halt) begin
        m_seen = 0;
      end else if (c) begin
        m_seen = m_seen + 1;
        if (m_seen >= eff) begin
          m_seen = 0; x_eg = 1'b1;
        end
      end
      // Period writes land after this edge's terminal decision.
      if (f)  m_period = (m_period & 32'hFF00) | int'(d);
      if (co) m_period = (m_period & 32'h00FF) | (int'(d) << 8);
    end
  endtask

  task automatic cens(input int n, input int every);
    for (int i = 0; i < n; i++) step(1, (i % every) == 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 0, 8'h00);
    // Period 4 with constant cen
    step(1, 0, 1, 0, 0, 8'h04);
    step(1, 0, 0, 1, 0, 8'h00);
    cens(20, 1);
    // Period 3, cen one clock in four
    step(1, 0, 1, 0, 0, 8'h03);
    step(1, 0, 0, 0, 1, 8'h00);
    cens(48, 4);
    // Shrink period below the running count
    step(1, 0, 1, 0, 0, 8'h10);
    step(1, 0, 0, 0, 1, 8'h00);
    cens(9, 1);
    step(1, 0, 1, 0, 0, 8'h05);
    cens(16, 1);
    // Shape write on a terminal cen
    step(1, 0, 1, 0, 0, 8'h03);
    step(1, 0, 0, 0, 1, 8'h00);
    cens(2, 1);
    step(1, 1, 0, 0, 1, 8'h0D);
    cens(8, 1);
    // Back-to-back shape writes
    step(1, 0, 0, 0, 1, 8'h01);
    step(1, 1, 0, 0, 1, 8'h07);
    step(1, 1, 0, 0, 1, 8'hFA);
    cens(4, 1);
    // Period zero, then period 2
    step(1, 0, 1, 0, 0, 8'h00);
    cens(20, 1);
    step(1, 0, 1, 0, 0, 8'h02);
    cens(10, 1);
    // Reset on a terminal cen
    step(1, 0, 1, 0, 0, 8'h03);
    step(1, 0, 0, 0, 1, 8'h05);
    cens(2, 1);
    step(0, 1, 0, 0, 0, 8'h00);
    step(1, 0, 1, 0, 0, 8'h03);
    cens(8, 1);
    // Coarse byte in use: period 0x0105, plus simultaneous fine+coarse
    step(1, 0, 1, 0, 0, 8'h05);
    step(1, 0, 0, 1, 0, 8'h01);
    cens(530, 1);
    step(1, 0, 1, 1, 0, 8'h00);
    cens(6, 1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, c, f, co, s;
      logic [7:0] d;
      r  = ($urandom_range(0, 299) != 0);
      c  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 24) == 0);
      co = ($urandom_range(0, 79) == 0);
      s  = ($urandom_range(0, 39) == 0);
      d  = 8'($urandom_range(0, 255));
      if (f && !co) d = 8'($urandom_range(0, 9));
      if (co) d = 8'($urandom_range(0, 1));
      step(r, c, f, co, s, d);
    end
    step(1, 0, 0, 0, 0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
